vga_window_timing_gen: RTL

//  Parametrised VGA timing generator: successor to the fixed 640x480 controller.

---
 rtl/vga_window_timing_gen.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_window_timing_gen.sv
// Parametrised VGA timing generator with a framed image window and a movable square sprite.
// Define VGA_SPRITE_EN to build the sprite path; without it the sprite inputs are ignored.
module vga_window_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int WIN_X0   = 240,
    parameter int WIN_Y0   = 141,
    parameter int WIN_W    = 256,
    parameter int WIN_H    = 256,
    parameter int SPR_SIZE = 32,
    parameter int RGB_W    = 3,
    parameter int CNT_W    = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pix_en_i,
    input  logic [RGB_W-1:0] frame_color_i,
    input  logic [RGB_W-1:0] pix_rgb_i,
    input  logic [7:0]       spr_x_i,
    input  logic [7:0]       spr_y_i,
    input  logic [RGB_W-1:0] spr_color_i,
    output logic [7:0]       pix_x_o,
    output logic [7:0]       pix_y_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             frame_start_o,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] WX0_C    = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] WX1_C    = CNT_W'(WIN_X0 + WIN_W);
    localparam logic [CNT_W-1:0] WY0_C    = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] WY1_C    = CNT_W'(WIN_Y0 + WIN_H);
    localparam logic [8:0]       SPR_LAST_C = 9'(SPR_SIZE - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    logic act_s, win_s, spr_s, hs_s, vs_s, fs_s;

    logic act1_q, win1_q, spr1_q, hs1_q, vs1_q, fs1_q;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs2_q, vs2_q, de2_q, fs2_q;

    // Raster counters: horizontal wraps at end of line and steps the vertical count.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en_i) begin
            if (hcnt_q == H_LAST_C) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST_C) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign act_s   = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    assign hs_s    = (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
    assign vs_s    = (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
    assign win_s   = (hcnt_q >= WX0_C) && (hcnt_q < WX1_C) &&
                     (vcnt_q >= WY0_C) && (vcnt_q < WY1_C);
    assign fs_s    = (hcnt_q == '0) && (vcnt_q == '0);
    assign pix_x_o = 8'(hcnt_q - WX0_C);
    assign pix_y_o = 8'(vcnt_q - WY0_C);

`ifdef VGA_SPRITE_EN
    logic [7:0] spr_x_q, spr_x_d;
    logic [7:0] spr_y_q, spr_y_d;

    // Sprite position is only taken at the top-left pixel so a frame never tears.
    always_comb begin
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
        if (pix_en_i && fs_s) begin
            spr_x_d = spr_x_i;
            spr_y_d = spr_y_i;
        end else begin
            spr_x_d = spr_x_q;
            spr_y_d = spr_y_q;
        end
    end

    // Sprite shadow registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spr_x_q <= 8'd0;
            spr_y_q <= 8'd0;
        end else begin
            spr_x_q <= spr_x_d;
            spr_y_q <= spr_y_d;
        end
    end

    // Nine-bit bounds so a sprite past the window edge clips instead of wrapping to column 0.
    assign spr_s = win_s &&
                   ({1'b0, pix_x_o} >= {1'b0, spr_x_q}) &&
                   ({1'b0, pix_x_o} <= ({1'b0, spr_x_q} + SPR_LAST_C)) &&
                   ({1'b0, pix_y_o} >= {1'b0, spr_y_q}) &&
                   ({1'b0, pix_y_o} <= ({1'b0, spr_y_q} + SPR_LAST_C));
`else
    logic unused_spr_s;
    assign unused_spr_s = ^{spr_x_i, spr_y_i};
    assign spr_s        = 1'b0;
`endif

    // Stage 1: region flags, aligned with the image pixel returned by the memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act1_q <= 1'b0;
            win1_q <= 1'b0;
            spr1_q <= 1'b0;
            hs1_q  <= ~SYNC_POL;
            vs1_q  <= ~SYNC_POL;
            fs1_q  <= 1'b0;
        end else if (pix_en_i) begin
            act1_q <= act_s;
            win1_q <= win_s;
            spr1_q <= spr_s;
            hs1_q  <= hs_s ? SYNC_POL : ~SYNC_POL;
            vs1_q  <= vs_s ? SYNC_POL : ~SYNC_POL;
            fs1_q  <= fs_s;
        end
    end

    // Colour priority: blanking, sprite, image, frame.
    always_comb begin
        rgb_d = '0;
        if (!act1_q) begin
            rgb_d = '0;
        end else if (spr1_q) begin
            rgb_d = spr_color_i;
        end else if (win1_q) begin
            rgb_d = pix_rgb_i;
        end else begin
            rgb_d = frame_color_i;
        end
    end

    // Stage 2: registered pin outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q <= '0;
            hs2_q <= ~SYNC_POL;
            vs2_q <= ~SYNC_POL;
            de2_q <= 1'b0;
            fs2_q <= 1'b0;
        end else if (pix_en_i) begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= act1_q;
            fs2_q <= fs1_q;
        end
    end

    assign rgb_o         = rgb_q;
    assign hsync_o       = hs2_q;
    assign vsync_o       = vs2_q;
    assign de_o          = de2_q;
    assign frame_start_o = fs2_q;
    assign hcount_o      = hcnt_q;
    assign vcount_o      = vcnt_q;

endmodule
